// File: rtl/status_led_ctrl_pkg.sv
// rtl/status_led_ctrl_pkg.sv - state encodings, LED levels and lamp-test step map for the status LED controller
package status_led_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_NORMAL = 3'd1,
    ST_WARN   = 3'd2,
    ST_CRIT   = 3'd3,
    ST_TEST   = 3'd4
  } led_state_t;

  localparam logic LED_ON  = 1'b1;
  localparam logic LED_OFF = 1'b0;

  typedef struct packed {
    logic g;
    logic a;
    logic b;
  } led_set_t;

  function automatic led_set_t test_step_leds(input logic [1:0] step);
    led_set_t r;
    r.g = LED_OFF;
    r.a = LED_OFF;
    r.b = LED_OFF;
    case (step)
      2'd0: r.g = LED_ON;
      2'd1: r.a = LED_ON;
      2'd2: r.b = LED_ON;
      default: begin
        r.g = LED_ON;
        r.a = LED_ON;
        r.b = LED_ON;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/status_led_ctrl_btn_debounce.sv
// rtl/status_led_ctrl_btn_debounce.sv - panel button synchronizer and debouncer with a one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYC = 250000
) (
  input  logic SYSCLK,
  input  logic RESET_N,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level_n;
  logic [CW-1:0] cnt;

  // cnt runs only while the synchronized input disagrees with the accepted level,
  // so any bounce back to the accepted level restarts the stability window.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_n <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level_n) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level_n <= sync2;
        press   <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - front-panel LED priority FSM with crit latch, locate timer and lamp test
module status_led_ctrl
  import status_led_ctrl_pkg::*;
#(
  parameter int DEB_CYC   = 250000,
  parameter int LOC_TMO_S = 240
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  input  logic       CLK_1HZ,
  input  logic       CLK_2HZ,
  input  logic       CLK_4HZ,
  input  logic       CLK_07S,
  input  logic       PWR_GOOD,
  input  logic       FAULT_WARN,
  input  logic       FAULT_CRIT,
  input  logic       FAULT_CLR,
  input  logic       LAMP_TEST,
  input  logic       LOCATE_BTN_N,
  output logic       LED_GREEN,
  output logic       LED_AMBER,
  output logic       LED_BLUE,
  output logic [2:0] LED_STATE
);

  localparam logic [7:0] LOC_LAST = 8'(LOC_TMO_S - 1);

  logic       pwr_s1, pwr_s;
  logic       warn_s1, warn_s;
  logic       crit_s1, crit_s;
  logic       hz1_d;
  logic       hz1_rise;
  logic       crit_lat;
  logic       loc_press;
  logic       loc_flag;
  logic [7:0] loc_cnt;
  logic       loc;
  led_state_t state;
  led_state_t resolved;
  logic [1:0] step;
  led_set_t   step_leds;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pwr_s1   <= 1'b0;
      pwr_s    <= 1'b0;
      warn_s1  <= 1'b0;
      warn_s   <= 1'b0;
      crit_s1  <= 1'b0;
      crit_s   <= 1'b0;
      hz1_d    <= 1'b0;
      crit_lat <= 1'b0;
    end else begin
      pwr_s1  <= PWR_GOOD;
      pwr_s   <= pwr_s1;
      warn_s1 <= FAULT_WARN;
      warn_s  <= warn_s1;
      crit_s1 <= FAULT_CRIT;
      crit_s  <= crit_s1;
      hz1_d   <= CLK_1HZ;
      if (crit_s) begin
        crit_lat <= 1'b1;
      end else if (FAULT_CLR) begin
        crit_lat <= 1'b0;
      end
    end
  end

  assign hz1_rise = CLK_1HZ & ~hz1_d;

  btn_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_loc_deb (
    .SYSCLK  (SYSCLK),
    .RESET_N (RESET_N),
    .btn_n   (LOCATE_BTN_N),
    .press   (loc_press)
  );

  // A press beats the timeout when both land in the same cycle.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      loc_flag <= 1'b0;
      loc_cnt  <= 8'd0;
    end else if (state == ST_OFF) begin
      loc_flag <= 1'b0;
      loc_cnt  <= 8'd0;
    end else if (loc_press) begin
      loc_flag <= ~loc_flag;
      loc_cnt  <= 8'd0;
    end else if (loc_flag && hz1_rise) begin
      if (loc_cnt == LOC_LAST) begin
        loc_flag <= 1'b0;
        loc_cnt  <= 8'd0;
      end else begin
        loc_cnt <= loc_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    resolved = ST_NORMAL;
    if (!pwr_s) begin
      resolved = ST_OFF;
    end else if (crit_lat) begin
      resolved = ST_CRIT;
    end else if (warn_s) begin
      resolved = ST_WARN;
    end
  end

  assign loc       = loc_flag & CLK_2HZ;
  assign step_leds = test_step_leds(step);

  // LEDs are decoded from the state held during this cycle, so they trail LED_STATE by one clock.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_OFF;
      step      <= 2'd0;
      LED_GREEN <= LED_OFF;
      LED_AMBER <= LED_OFF;
      LED_BLUE  <= LED_OFF;
    end else begin
      if (state == ST_TEST) begin
        if (hz1_rise) begin
          if (step == 2'd3) begin
            state <= resolved;
            step  <= 2'd0;
          end else begin
            step <= step + 2'd1;
          end
        end
      end else if (LAMP_TEST) begin
        state <= ST_TEST;
        step  <= 2'd0;
      end else begin
        state <= resolved;
      end

      case (state)
        ST_NORMAL: begin
          LED_GREEN <= LED_ON;
          LED_AMBER <= LED_OFF;
          LED_BLUE  <= loc;
        end
        ST_WARN: begin
          LED_GREEN <= LED_ON;
          LED_AMBER <= CLK_07S;
          LED_BLUE  <= loc;
        end
        ST_CRIT: begin
          LED_GREEN <= LED_OFF;
          LED_AMBER <= CLK_4HZ;
          LED_BLUE  <= loc;
        end
        ST_TEST: begin
          LED_GREEN <= step_leds.g;
          LED_AMBER <= step_leds.a;
          LED_BLUE  <= step_leds.b;
        end
        default: begin
          LED_GREEN <= LED_OFF;
          LED_AMBER <= LED_OFF;
          LED_BLUE  <= LED_OFF;
        end
      endcase
    end
  end

  assign LED_STATE = state;

endmodule

// File: tb/tb_status_led_ctrl.sv
// tb/tb_status_led_ctrl.sv - scoreboard bench for status_led_ctrl with directed, hand-timed vectors
module tb_status_led_ctrl;

  localparam int K_STATE = 0;
  localparam int K_LEDS  = 1;
  localparam int K_FLAG  = 2;
  localparam int K_CNT   = 3;
  localparam int K_PRESS = 4;
  localparam int K_PCNT  = 5;

  logic       SYSCLK = 1'b0;
  logic       RESET_N;
  logic       CLK_1HZ, CLK_2HZ, CLK_4HZ, CLK_07S;
  logic       PWR_GOOD, FAULT_WARN, FAULT_CRIT, FAULT_CLR, LAMP_TEST, LOCATE_BTN_N;
  logic       LED_GREEN, LED_AMBER, LED_BLUE;
  logic [2:0] LED_STATE;

  typedef struct {
    int          stamp;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   press_total = 0;

  status_led_ctrl #(
    .DEB_CYC   (8),
    .LOC_TMO_S (3)
  ) dut (
    .SYSCLK       (SYSCLK),
    .RESET_N      (RESET_N),
    .CLK_1HZ      (CLK_1HZ),
    .CLK_2HZ      (CLK_2HZ),
    .CLK_4HZ      (CLK_4HZ),
    .CLK_07S      (CLK_07S),
    .PWR_GOOD     (PWR_GOOD),
    .FAULT_WARN   (FAULT_WARN),
    .FAULT_CRIT   (FAULT_CRIT),
    .FAULT_CLR    (FAULT_CLR),
    .LAMP_TEST    (LAMP_TEST),
    .LOCATE_BTN_N (LOCATE_BTN_N),
    .LED_GREEN    (LED_GREEN),
    .LED_AMBER    (LED_AMBER),
    .LED_BLUE     (LED_BLUE),
    .LED_STATE    (LED_STATE)
  );

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_STATE: return {29'd0, LED_STATE};
      K_LEDS:  return {29'd0, LED_GREEN, LED_AMBER, LED_BLUE};
      K_FLAG:  return {31'd0, dut.loc_flag};
      K_CNT:   return {24'd0, dut.loc_cnt};
      K_PRESS: return {31'd0, dut.u_loc_deb.press};
      default: return press_total;
    endcase
  endfunction

  // Monitor: samples on the falling edge and retires every expectation due this cycle.
  always @(negedge SYSCLK) begin
    logic [31:0] act;
    if (dut.u_loc_deb.press === 1'b1) press_total = press_total + 1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].stamp == cyc) begin
        act = actual(sb[i].kind);
        n_vec = n_vec + 1;
        if (act !== sb[i].exp) begin
          n_miss = n_miss + 1;
          $display("FAIL %s @cycle %0d: got %0h expected %0h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int d, input int kind, input logic [31:0] val, input string name);
    chk_t e;
    e.stamp = cyc + d;
    e.kind  = kind;
    e.exp   = val;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // One CLK_1HZ rising edge; the DUT acts on it at the next posedge.
  task automatic one_hz();
    CLK_1HZ = 1'b1;
    tick(2);
    CLK_1HZ = 1'b0;
    tick(2);
  endtask

  initial begin
    #200000;
    n_miss = n_miss + 1;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    RESET_N = 1'b0;
    CLK_1HZ = 1'b0; CLK_2HZ = 1'b0; CLK_4HZ = 1'b0; CLK_07S = 1'b0;
    PWR_GOOD = 1'b1; FAULT_WARN = 1'b0; FAULT_CRIT = 1'b0; FAULT_CLR = 1'b0;
    LAMP_TEST = 1'b0; LOCATE_BTN_N = 1'b1;
    tick(3);
    expect_at(1, K_STATE, 0, "rst_state");
    expect_at(1, K_LEDS, 0, "rst_leds");
    expect_at(1, K_FLAG, 0, "rst_loc_flag");
    tick(2);

    // Power-up to NORMAL: two sync flops then the FSM step.
    RESET_N = 1'b1;
    expect_at(2, K_STATE, 0, "pwr_sync_off");
    expect_at(3, K_STATE, 1, "normal_state");
    expect_at(4, K_LEDS, 3'b100, "normal_leds");
    tick(14);

    // Critical fault latch and clear qualification.
    FAULT_CRIT = 1'b1;
    CLK_4HZ = 1'b1;
    expect_at(4, K_STATE, 3, "crit_state");
    expect_at(5, K_LEDS, 3'b010, "crit_amber_hi");
    tick(6);
    CLK_4HZ = 1'b0;
    expect_at(1, K_LEDS, 3'b000, "crit_amber_lo");
    tick(1);
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
    tick(2);
    FAULT_CRIT = 1'b0;
    expect_at(4, K_STATE, 3, "crit_after_1st_clr");
    tick(4);
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
    expect_at(1, K_STATE, 1, "normal_after_2nd_clr");
    expect_at(2, K_LEDS, 3'b100, "normal_leds_after_clr");
    tick(6);

    // Bounced locate press: only the final held low is accepted, 2 sync + 8 stable cycles later.
    CLK_2HZ = 1'b1;
    for (int k = 0; k < 7; k++) begin
      LOCATE_BTN_N = (k % 2 == 1);
      if (k < 6) tick(3);
    end
    expect_at(1, K_PCNT, 0, "no_press_in_bounce");
    expect_at(9, K_PRESS, 0, "press_not_early");
    expect_at(10, K_PRESS, 1, "press_timing");
    expect_at(11, K_FLAG, 1, "loc_flag_set");
    expect_at(11, K_CNT, 0, "loc_cnt_zero");
    expect_at(12, K_LEDS, 3'b101, "loc_blue_on");
    expect_at(12, K_PCNT, 1, "single_press");
    tick(13);
    CLK_2HZ = 1'b0;
    expect_at(1, K_LEDS, 3'b100, "loc_blue_follow_2hz");
    tick(1);
    LOCATE_BTN_N = 1'b1;
    expect_at(11, K_PCNT, 1, "no_release_press");
    tick(12);
    CLK_2HZ = 1'b1;
    one_hz();
    one_hz();
    expect_at(1, K_CNT, 2, "loc_cnt_two");
    expect_at(1, K_FLAG, 1, "loc_flag_before_tmo");
    expect_at(1, K_LEDS, 3'b101, "loc_blue_before_tmo");
    tick(1);
    expect_at(1, K_FLAG, 0, "loc_timeout_flag");
    expect_at(1, K_CNT, 0, "loc_timeout_cnt");
    expect_at(2, K_LEDS, 3'b100, "loc_timeout_blue");
    one_hz();

    // Press landing on the timeout cycle.
    LOCATE_BTN_N = 1'b0;
    expect_at(11, K_FLAG, 1, "relock_flag");
    tick(12);
    LOCATE_BTN_N = 1'b1;
    tick(12);
    one_hz();
    one_hz();
    LOCATE_BTN_N = 1'b0;
    expect_at(10, K_FLAG, 1, "pre_coinc_flag");
    expect_at(10, K_CNT, 2, "pre_coinc_cnt");
    expect_at(11, K_FLAG, 0, "coinc_flag");
    expect_at(11, K_CNT, 0, "coinc_cnt");
    expect_at(12, K_PCNT, 3, "coinc_press_total");
    tick(10);
    CLK_1HZ = 1'b1;
    tick(2);
    CLK_1HZ = 1'b0;
    tick(2);
    LOCATE_BTN_N = 1'b1;
    tick(12);

    // Lamp test from WARN; crit raised during step1 is latched and taken on exit.
    FAULT_WARN = 1'b1;
    CLK_07S = 1'b1;
    expect_at(3, K_STATE, 2, "warn_state");
    expect_at(4, K_LEDS, 3'b110, "warn_leds");
    tick(5);
    CLK_07S = 1'b0;
    expect_at(1, K_LEDS, 3'b100, "warn_blink_low");
    tick(2);
    LAMP_TEST = 1'b1;
    expect_at(1, K_STATE, 4, "test_enter");
    expect_at(2, K_LEDS, 3'b100, "test_step0");
    tick(1);
    LAMP_TEST = 1'b0;
    tick(3);
    expect_at(2, K_LEDS, 3'b010, "test_step1");
    one_hz();
    FAULT_CRIT = 1'b1;
    LAMP_TEST = 1'b1;
    expect_at(2, K_LEDS, 3'b010, "test_retrigger_ignored");
    tick(1);
    LAMP_TEST = 1'b0;
    tick(4);
    CLK_4HZ = 1'b1;
    expect_at(2, K_LEDS, 3'b001, "test_step2");
    one_hz();
    expect_at(1, K_STATE, 4, "test_hold_step3");
    expect_at(2, K_LEDS, 3'b111, "test_step3");
    one_hz();
    expect_at(1, K_STATE, 3, "test_exit_crit");
    expect_at(2, K_LEDS, 3'b010, "crit_after_test");
    one_hz();
    FAULT_CRIT = 1'b0;
    FAULT_WARN = 1'b0;
    tick(4);

    // Locate in CRIT, power loss, lamp test from OFF, then reset mid-test.
    LOCATE_BTN_N = 1'b0;
    expect_at(12, K_LEDS, 3'b011, "crit_locate_leds");
    expect_at(12, K_PCNT, 4, "crit_locate_press");
    tick(14);
    PWR_GOOD = 1'b0;
    expect_at(3, K_STATE, 0, "pwr_drop_off");
    expect_at(4, K_FLAG, 0, "off_clears_loc");
    expect_at(4, K_LEDS, 3'b000, "off_leds");
    tick(6);
    LAMP_TEST = 1'b1;
    expect_at(1, K_STATE, 4, "test_from_off");
    tick(1);
    LAMP_TEST = 1'b0;
    expect_at(2, K_LEDS, 3'b010, "off_test_step1");
    one_hz();
    RESET_N = 1'b0;
    expect_at(1, K_STATE, 0, "rst_mid_test_state");
    expect_at(1, K_LEDS, 3'b000, "rst_mid_test_leds");
    expect_at(1, K_FLAG, 0, "rst_mid_test_flag");
    expect_at(1, K_CNT, 0, "rst_mid_test_cnt");
    tick(3);
    RESET_N = 1'b1;
    expect_at(4, K_STATE, 0, "post_rst_off");
    expect_at(4, K_LEDS, 3'b000, "post_rst_leds");
    tick(6);
    PWR_GOOD = 1'b1;
    expect_at(3, K_STATE, 1, "post_rst_normal");
    expect_at(4, K_LEDS, 3'b100, "no_residual_step");
    expect_at(4, K_FLAG, 0, "no_residual_loc");
    tick(8);

    n_vec = n_vec + 1;
    if (LED_STATE !== 3'd1) begin
      n_miss = n_miss + 1;
      $display("FAIL final_state: got %0h expected 1", LED_STATE);
    end
    n_vec = n_vec + 1;
    if ({LED_GREEN, LED_AMBER, LED_BLUE} !== 3'b100) begin
      n_miss = n_miss + 1;
      $display("FAIL final_leds: got %0h expected 4", {LED_GREEN, LED_AMBER, LED_BLUE});
    end
    n_vec = n_vec + 1;
    if (dut.loc_flag !== 1'b0) begin
      n_miss = n_miss + 1;
      $display("FAIL final_loc_flag: got %0h expected 0", dut.loc_flag);
    end

    foreach (sb[i]) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got unchecked expected check at cycle %0d", sb[i].name, sb[i].stamp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
